// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
//   Decode -> execute pipeline stage. Drives register file read addresses,
//   forwards same-cycle writeback data, keeps a per-register busy scoreboard
//   to stall on RAW/WAW hazards, and holds one valid/ready output slot.
//
// Ports
//   i_Clk, i_Rst            clock, synchronous active-high reset
//   i_InstrValid/o_InstrReady  decoded instruction handshake
//   i_Rs1/i_Rs2/i_Rd, i_UseRs1/i_UseRs2/i_WritesRd, i_Ctrl  instruction fields
//   o_Addr1/o_Addr2, i_RD1/i_RD2  register file read port (combinational)
//   i_WbValid/i_WbAddr/i_WbData   writeback (also the RF write port)
//   o_OpValid/i_OpReady     execute handshake
//   o_Op1/o_Op2/o_Rd/o_WritesRd/o_Ctrl  slot contents
//   o_Busy                  scoreboard, one bit per register (bit 0 always 0)
// ---------------------------------------------------------------------------
module operand_fetch #(
    parameter  int REG_WIDTH  = 32,
    parameter  int REG_DEPTH  = 32,
    parameter  int CTRL_WIDTH = 16,
    localparam int ADDR_W     = $clog2(REG_DEPTH)
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_InstrValid,
    output logic                  o_InstrReady,
    input  logic [ADDR_W-1:0]     i_Rs1,
    input  logic [ADDR_W-1:0]     i_Rs2,
    input  logic [ADDR_W-1:0]     i_Rd,
    input  logic                  i_UseRs1,
    input  logic                  i_UseRs2,
    input  logic                  i_WritesRd,
    input  logic [CTRL_WIDTH-1:0] i_Ctrl,
    output logic [ADDR_W-1:0]     o_Addr1,
    output logic [ADDR_W-1:0]     o_Addr2,
    input  logic [REG_WIDTH-1:0]  i_RD1,
    input  logic [REG_WIDTH-1:0]  i_RD2,
    input  logic                  i_WbValid,
    input  logic [ADDR_W-1:0]     i_WbAddr,
    input  logic [REG_WIDTH-1:0]  i_WbData,
    output logic                  o_OpValid,
    input  logic                  i_OpReady,
    output logic [REG_WIDTH-1:0]  o_Op1,
    output logic [REG_WIDTH-1:0]  o_Op2,
    output logic [ADDR_W-1:0]     o_Rd,
    output logic                  o_WritesRd,
    output logic [CTRL_WIDTH-1:0] o_Ctrl,
    output logic [REG_DEPTH-1:0]  o_Busy
);

    logic [REG_DEPTH-1:0] r_Busy;
    logic [REG_DEPTH-1:0] w_Clr;
    logic [REG_DEPTH-1:0] w_Set;
    logic [REG_DEPTH-1:0] w_EBusy;
    logic                 w_Raw1, w_Raw2, w_Waw, w_SlotFree, w_Issue;
    logic [REG_WIDTH-1:0] w_Op1, w_Op2;

    assign o_Addr1 = i_Rs1;
    assign o_Addr2 = i_Rs2;

    // x0 is never tracked: no clear, no set, so it can never hazard.
    for (genvar r = 0; r < REG_DEPTH; r++) begin : g_sb
        if (r == 0) begin : g_zero
            assign w_Clr[r] = 1'b0;
            assign w_Set[r] = 1'b0;
        end else begin : g_reg
            assign w_Clr[r] = i_WbValid & (i_WbAddr == ADDR_W'(r));
            assign w_Set[r] = w_Issue & i_WritesRd & (i_Rd == ADDR_W'(r));
        end
    end

    // A register being written back this cycle no longer blocks issue.
    assign w_EBusy = r_Busy & ~w_Clr;

    assign w_Raw1       = i_UseRs1 & w_EBusy[i_Rs1];
    assign w_Raw2       = i_UseRs2 & w_EBusy[i_Rs2];
    assign w_Waw        = i_WritesRd & w_EBusy[i_Rd];
    assign w_SlotFree   = ~o_OpValid | i_OpReady;
    assign o_InstrReady = w_SlotFree & ~w_Raw1 & ~w_Raw2 & ~w_Waw;
    assign w_Issue      = i_InstrValid & o_InstrReady;

    // The RF write lands at the edge, so its read still returns the old value;
    // a matching writeback must be forwarded instead.
    assign w_Op1 = (i_Rs1 == '0)   ? '0 :
                   w_Clr[i_Rs1]    ? i_WbData : i_RD1;
    assign w_Op2 = (i_Rs2 == '0)   ? '0 :
                   w_Clr[i_Rs2]    ? i_WbData : i_RD2;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_OpValid  <= 1'b0;
            o_Op1      <= '0;
            o_Op2      <= '0;
            o_Rd       <= '0;
            o_WritesRd <= 1'b0;
            o_Ctrl     <= '0;
            r_Busy     <= '0;
        end else begin
            // Set is ORed after clear so a same-cycle reissue keeps the bit.
            r_Busy <= (r_Busy & ~w_Clr) | w_Set;
            if (w_Issue) begin
                o_OpValid  <= 1'b1;
                o_Op1      <= w_Op1;
                o_Op2      <= w_Op2;
                o_Rd       <= i_Rd;
                o_WritesRd <= i_WritesRd;
                o_Ctrl     <= i_Ctrl;
            end else if (i_OpReady) begin
                o_OpValid <= 1'b0;
            end
        end
    end

    assign o_Busy = r_Busy;

endmodule
